// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM frame serializer.
package pwm_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam int DEF_N_CH    = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_PERIOD  = 100;
  localparam int DEF_CLK_DIV = 2;

  // Cycles per frame with enable held: IDLE + LOAD + shift bits + latch
  function automatic int frame_len(input int n_ch, input int clk_div);
    return 2 + 2 * clk_div * n_ch + clk_div;
  endfunction

  localparam int DEF_FRAME_LEN = frame_len(DEF_N_CH, DEF_CLK_DIV);

endpackage

// File: rtl/pwm_bit_shifter.sv
// Serializes an N_CH-bit word MSB first onto ser_clk/ser_data.
// Each bit is CLK_DIV cycles with ser_clk low, then CLK_DIV cycles high;
// ser_data only moves on the high->low transition of ser_clk.
module pwm_bit_shifter
  import pwm_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_CH-1:0] word,
  output logic            ser_clk,
  output logic            ser_data,
  output logic            done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             active_q, active_d;
  logic             hi_q, hi_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N_CH-1:0]  sreg_q, sreg_d;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_data_q, ser_data_d;

  logic div_last;
  logic bit_last;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == BIT_W'(N_CH - 1));

  // Last cycle of the last bit; lets the sequencer enter LATCH with no gap
  assign done     = active_q & hi_q & div_last & bit_last;
  assign ser_clk  = ser_clk_q;
  assign ser_data = ser_data_q;

  // Next-state: divider phase, bit index and shift register
  always_comb begin
    active_d   = active_q;
    hi_d       = hi_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sreg_d     = sreg_q;
    ser_clk_d  = ser_clk_q;
    ser_data_d = ser_data_q;
    if (start) begin
      active_d   = 1'b1;
      hi_d       = 1'b0;
      div_d      = '0;
      bit_d      = '0;
      sreg_d     = word;
      ser_clk_d  = 1'b0;
      ser_data_d = word[N_CH-1];
    end else if (active_q) begin
      if (div_last) begin
        div_d = '0;
        if (!hi_q) begin
          hi_d      = 1'b1;
          ser_clk_d = 1'b1;
        end else begin
          hi_d      = 1'b0;
          ser_clk_d = 1'b0;
          if (bit_last) begin
            active_d   = 1'b0;
            ser_data_d = 1'b0;
          end else begin
            bit_d      = bit_q + 1'b1;
            sreg_d     = sreg_q << 1;
            ser_data_d = sreg_d[N_CH-1];
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q   <= 1'b0;
      hi_q       <= 1'b0;
      div_q      <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      hi_q       <= hi_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sreg_q     <= sreg_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
    end
  end

endmodule

// File: rtl/pwm_frame_serializer.sv
// PWM driver for a serial-in/parallel-out latching shift register.
// Holds per-channel duty values and a shared period counter; each frame
// snapshots one compare bit per channel, shifts them out and latches.
module pwm_frame_serializer
  import pwm_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [$clog2(N_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]        wr_duty,
  output logic                    ser_clk,
  output logic                    ser_data,
  output logic                    ser_latch,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int WCH_W = $clog2(N_CH);
  localparam int LAT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [LAT_W-1:0]             lat_q, lat_d;
  logic [N_CH-1:0][CNT_W-1:0]   duty_q, duty_d;
  logic                         ser_latch_q, ser_latch_d;
  logic                         busy_q, busy_d;
  logic                         frame_done_q, frame_done_d;

  logic [N_CH-1:0] cmp;
  logic            sh_start;
  logic            sh_done;
  logic            lat_last;

  assign lat_last   = (lat_q == LAT_W'(CLK_DIV - 1));
  assign ser_latch  = ser_latch_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Duty register file write; out-of-range channel indices are dropped
  always_comb begin
    duty_d = duty_q;
    if (wr_en && ({1'b0, wr_ch} < (WCH_W + 1)'(N_CH)))
      duty_d[wr_ch] = wr_duty;
  end

  // Per-channel compare, widened so duty >= 2^CNT_W-1 still reads as always-on
  always_comb begin
    cmp = '0;
    for (int k = 0; k < N_CH; k++)
      cmp[k] = ({1'b0, count_q} < {1'b0, duty_q[k]});
  end

  // Frame sequencer next-state, period counter and registered output values
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    count_d  = count_q;
    sh_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        sh_start = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sh_done) begin
          state_d = ST_LATCH;
          lat_d   = '0;
        end
      end
      ST_LATCH: begin
        if (lat_last) begin
          state_d = ST_IDLE;
          count_d = (count_q == CNT_W'(PERIOD - 1)) ? '0 : count_q + 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ser_latch_d  = (state_d == ST_LATCH);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_LATCH) && (lat_d == LAT_W'(CLK_DIV - 1));
  end

  // State, counter, duty and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      lat_q        <= '0;
      duty_q       <= '0;
      ser_latch_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lat_q        <= lat_d;
      duty_q       <= duty_d;
      ser_latch_q  <= ser_latch_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  pwm_bit_shifter #(
    .N_CH    (N_CH),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (sh_start),
    .word     (cmp),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .done     (sh_done)
  );

endmodule

// File: tb/tb_pwm_frame_serializer.sv
// Scoreboard bench: stimulus pushes expected latched bytes, a monitor
// models the external shift register and compares on each frame_done.
module tb_pwm_frame_serializer;

  localparam int N_CH    = 8;
  localparam int CNT_W   = 8;
  localparam int PERIOD  = 100;
  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_ch = '0;
  logic [7:0] wr_duty = '0;
  logic       ser_clk, ser_data, ser_latch, busy, frame_done;

  always #5 clk = ~clk;

  pwm_frame_serializer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .ser_clk(ser_clk),
    .ser_data(ser_data), .ser_latch(ser_latch), .busy(busy),
    .frame_done(frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         hi_cnt[8];
  int         m_count;
  int         m_duty[8];

  // monitor state
  logic [7:0] sr = '0, lat = '0, last_lat = '0;
  logic       prev_clk = 1'b0, prev_latch = 1'b0, prev_data = 1'b0;
  int nrise = 0, last_rise_t = 0, latch_t = 0, last_nrise = 0, last_gap = 0;
  int latch_pulses = 0, frames_done = 0, viol_data = 0, viol_latch = 0;
  int done_t = 0, done_t_prev = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: external register model plus per-frame scoreboard compare
  initial forever begin
    @(negedge clk);
    if (reset) nrise = 0;
    if (ser_clk && !prev_clk) begin
      sr = {sr[6:0], ser_data};
      nrise++;
      last_rise_t = cyc;
    end
    if (ser_clk && (ser_data !== prev_data)) viol_data++;
    if (ser_latch && (ser_clk || ser_data)) viol_latch++;
    if (ser_latch && !prev_latch) begin
      lat = sr;
      latch_pulses++;
      latch_t = cyc;
    end
    if (frame_done) begin
      frames_done++;
      last_lat    = lat;
      last_nrise  = nrise;
      last_gap    = latch_t - last_rise_t;
      nrise       = 0;
      done_t_prev = done_t;
      done_t      = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got %0d expected no frame", lat);
      end else begin
        chk("frame_bits", {24'd0, lat}, {24'd0, exp_q.pop_front()});
        for (int k = 0; k < 8; k++) if (lat[k]) hi_cnt[k]++;
      end
    end
    prev_clk   = ser_clk;
    prev_data  = ser_data;
    prev_latch = ser_latch;
  end

  function automatic logic [7:0] model();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (m_count < m_duty[k]);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, ser_clk, ser_data, ser_latch, busy, frame_done}, 0);
    reset = 1'b0;
    m_count = 0;
    for (int k = 0; k < 8; k++) m_duty[k] = 0;
    exp_q.delete();
  endtask

  task automatic wr(input int ch, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = ch[2:0]; wr_duty = v[7:0];
    m_duty[ch] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (i == 200) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model());
      wait_done("run_frames");
      m_count = (m_count + 1) % PERIOD;
    end
  endtask

  task automatic clr_hi();
    for (int k = 0; k < 8; k++) hi_cnt[k] = 0;
  endtask

  initial begin
    int t_busy, t_rise, t_lat, t_done, lat_cycles, busy36, lp, fd, busy_seen;

    // full period with duties 10..80
    do_reset();
    for (int k = 0; k < 8; k++) wr(k, 10 * (k + 1));
    clr_hi();
    enable = 1'b1;
    run_frames(26);
    chk("count25_byte", {24'd0, last_lat}, 32'hFC);
    chk("count25_nrise", last_nrise, 8);
    chk("latch_after_8th_rise", last_gap, 2);
    chk("frame_length", done_t - done_t_prev, 36);
    run_frames(74);
    for (int k = 0; k < 8; k++) chk("period_hi_count", hi_cnt[k], 10 * (k + 1));
    run_frames(1);
    chk("wrap_count0_byte", {24'd0, last_lat}, 32'hFF);
    enable = 1'b0;

    // duty 0 never on, duty 255 always on
    do_reset();
    for (int k = 0; k < 8; k++) wr(k, (k == 3) ? 0 : (k == 4) ? 255 : 10 * (k + 1));
    clr_hi();
    enable = 1'b1;
    run_frames(100);
    enable = 1'b0;
    chk("duty0_hi", hi_cnt[3], 0);
    chk("duty255_hi", hi_cnt[4], 100);
    chk("duty10_hi", hi_cnt[0], 10);
    chk("duty80_hi", hi_cnt[7], 80);

    // write in LOAD cycle, frame timing from IDLE, enable drop mid-SHIFT
    do_reset();
    for (int k = 0; k < 8; k++) wr(k, 10 * (k + 1));
    enable = 1'b1;
    run_frames(40);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hF4);
    @(negedge clk);
    enable = 1'b1;
    t_busy = -1; t_rise = -1; t_lat = -1; t_done = -1; lat_cycles = 0; busy36 = 1;
    for (int t = 1; t <= 36; t++) begin
      @(negedge clk);
      if (t == 1) begin wr_en = 1'b1; wr_ch = 3'd2; wr_duty = 8'd90; end
      if (t == 2) wr_en = 1'b0;
      if (busy && t_busy < 0) t_busy = t;
      if (ser_clk && t_rise < 0) t_rise = t;
      if (ser_latch && t_lat < 0) t_lat = t;
      if (frame_done && t_done < 0) t_done = t;
      if (ser_latch) lat_cycles++;
      if (t == 36) busy36 = busy;
    end
    chk("busy_rise_t", t_busy, 1);
    chk("first_ser_clk_t", t_rise, 4);
    chk("latch_t", t_lat, 34);
    chk("frame_done_t", t_done, 35);
    chk("latch_cycles", lat_cycles, 2);
    chk("busy_fall", busy36, 0);
    wait_done("second_frame");
    repeat (10) @(negedge clk);
    exp_q.push_back(8'hF4);
    enable = 1'b0;
    wait_done("drop_enable");
    @(negedge clk);
    chk("busy_after_drop", {31'd0, busy}, 0);
    lp = latch_pulses; fd = frames_done; busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("no_restart_busy", busy_seen, 0);
    chk("no_restart_frames", frames_done, fd);
    chk("no_restart_latch", latch_pulses, lp);

    // reset in the middle of SHIFT
    do_reset();
    for (int k = 0; k < 8; k++) wr(k, 10 * (k + 1));
    enable = 1'b1;
    lp = latch_pulses;
    repeat (12) @(negedge clk);
    chk("busy_before_reset", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {27'd0, ser_clk, ser_data, ser_latch, busy, frame_done}, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("no_partial_latch", latch_pulses, lp);
    m_count = 0;
    for (int k = 0; k < 8; k++) m_duty[k] = 0;
    wr(0, 1);
    exp_q.push_back(8'h01);
    @(negedge clk);
    enable = 1'b1;
    wait_done("post_reset_frame");
    enable = 1'b0;
    repeat (4) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    chk("data_changes_while_clk_high", viol_data, 0);
    chk("latch_phase_clk_data", viol_latch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_frame_serializer.md
# pwm_frame_serializer

Upstream driver for the 8-bit serial-in/parallel-out latching shift register. Holds one duty value per channel and runs a shared PWM period counter. Each PWM step it computes one compare bit per channel and shifts the bits out serially. It then pulses the latch so all channel outputs update together.

## Interface

Parameters:
- N_CH, 8, number of PWM channels (bits per frame)
- CNT_W, 8, width of duty values and period counter
- PERIOD, 100, PWM steps per period; counter runs 0..PERIOD-1
- CLK_DIV, 2, system clocks per ser_clk half-period (>=1)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; sampled in IDLE to start a frame
- wr_en  in  1  duty write strobe
- wr_ch  in  $clog2(N_CH)  channel index for the write
- wr_duty  in  CNT_W  duty value for the write
- ser_clk  out  1  shift clock to register `clk`
- ser_data  out  1  serial bit to register `d0`
- ser_latch  out  1  latch strobe to register `latch`
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse on the last LATCH cycle

## Operation

- States: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
- IDLE: outputs low; if enable=1, go to LOAD next cycle.
- LOAD (1 cycle): snapshot cmp[k] = (count < duty[k]) for every k. Widen both operands to CNT_W+1 bits before comparing.
- SHIFT: send N_CH bits, channel N_CH-1 first and channel 0 last, so channel k lands in register stage k.
  - Each bit is 2*CLK_DIV cycles long: ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ser_data is stable for the whole bit and changes only while ser_clk is low.
- LATCH: ser_latch=1 for CLK_DIV cycles with ser_clk=0 and ser_data=0.
  - On the last LATCH cycle: frame_done=1 and count advances (PERIOD-1 wraps to 0).
  - Then go to IDLE.
- Duty semantics:
  - duty=0: channel always 0.
  - duty>=PERIOD: channel always 1.
  - Otherwise the channel is high for `duty` of every PERIOD frames.
- Writes:
  - wr_en writes duty[wr_ch] at the clock edge; accepted in any state.
  - The new value is visible from the next cycle.
  - A write during or after LOAD affects the following frame only; a write in the same cycle as LOAD is not seen by that snapshot.
  - wr_ch >= N_CH is ignored.
- enable dropping mid-frame: the current frame completes, including the latch, then the block stays in IDLE.

## Timing

- Reset values:
  - ser_clk, ser_data, ser_latch, busy, frame_done all 0.
  - All duty registers 0; count 0; state IDLE.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously, with no partial latch pulse. The frame is discarded and count is not advanced.
- With enable held high, frame length = 2 + 2*CLK_DIV*N_CH + CLK_DIV cycles (36 at defaults).
- First ser_clk rise = cycle 2 + CLK_DIV after IDLE sees enable.
- Full PWM period = PERIOD frames.
- busy rises the cycle after IDLE samples enable and falls the cycle after frame_done.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Shared package pwm_pkg holds:
  - state typedef (IDLE, LOAD, SHIFT, LATCH)
  - default N_CH, CNT_W, PERIOD, CLK_DIV
  - localparam for frame length
- One sub-module, pwm_bit_shifter: generates ser_clk and ser_data from a loaded N_CH-bit word.
  - Internally: divider counter plus bit index.
  - Handshake: `start` in, `done` out.
- Top level holds the duty register file, period counter, compare logic and FSM.

## Test plan

- Reset, then duty[0..7]=10,20,...,80, enable=1 for 100 frames. Per channel, count frames with the latched bit high: required 10,20,...,80. After frame 100, count=0.
- Sample one frame with count=25 and duties as above. Serial order must be 1,1,1,1,1,1,0,0 (ch7 first); ser_latch high 2 cycles after the 8th ser_clk rise.
- duty[3]=0 and duty[4]=255: ch3 never 1, ch4 always 1 over a full period.
- Write duty[2]=90 in the LOAD cycle. That frame uses the old value; the next frame uses 90.
- Assert reset in the middle of SHIFT. Outputs go 0 immediately; no ser_latch pulse; after release, count is unchanged from its pre-frame value (0 after a fresh reset).
- Drop enable during SHIFT: frame_done still pulses once and busy falls the next cycle; no new LOAD follows.
